// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: 4-way round-robin owner of the shared mux/ffd output path.
// Build macro RR_HOLD_LIMIT_EN enables the per-grant burst limit (HOLD_MAX words).
module rr_mux_arbiter #(
   parameter int WIDTH    = 8,
   parameter int HOLD_MAX = 4
) (
   input  logic             iClk,
   input  logic             iClr,
   input  logic [3:0]       iReq,
   input  logic [WIDTH-1:0] iData0,
   input  logic [WIDTH-1:0] iData1,
   input  logic [WIDTH-1:0] iData2,
   input  logic [WIDTH-1:0] iData3,
   output logic [3:0]       oGnt,
   output logic [1:0]       oSel,
   output logic             oEnb,
   output logic [WIDTH-1:0] oData,
   output logic             oValid
);

   localparam logic [3:0] CNT_LIM = 4'(HOLD_MAX - 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       gnt_d;
   logic [1:0]       sel_d;
   logic             enb_d;
   logic [WIDTH-1:0] data_d;
   logic             valid_d;

   logic [3:0]       rot;
   logic [1:0]       off;
   logic [1:0]       win;
   logic             own_req;
   logic             at_lim;
   logic             rel;
   logic [WIDTH-1:0] mux;

   // rotate requests so bit 0 is the pointer slot, then take the first set bit
   always_comb begin
      rot = 4'({iReq, iReq} >> ptr_q);
      off = 2'd0;
      priority case (1'b1)
         rot[0]:  off = 2'd0;
         rot[1]:  off = 2'd1;
         rot[2]:  off = 2'd2;
         rot[3]:  off = 2'd3;
         default: off = 2'd0;
      endcase
      win = ptr_q + off;
   end

   // shared 4:1 data mux driven by the current select
   always_comb begin
      mux = iData0;
      unique case (oSel)
         2'd0: mux = iData0;
         2'd1: mux = iData1;
         2'd2: mux = iData2;
         2'd3: mux = iData3;
      endcase
   end

   assign own_req = iReq[oSel];
   assign at_lim  = (cnt_q == CNT_LIM);

   // next-state and next-output logic; every register holds by default
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = oGnt;
      sel_d   = oSel;
      enb_d   = oEnb;
      data_d  = oData;
      valid_d = 1'b0;
      rel     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|iReq) begin
               state_d = GRANT;
               gnt_d   = 4'b0001 << win;
               sel_d   = win;
               enb_d   = 1'b1;
               cnt_d   = 4'd0;
            end
         end
         GRANT: begin
            if (own_req) begin
               data_d  = mux;
               valid_d = 1'b1;
`ifdef RR_HOLD_LIMIT_EN
               cnt_d   = cnt_q + 4'd1;
`else
               cnt_d   = at_lim ? cnt_q : cnt_q + 4'd1;
`endif
            end
`ifdef RR_HOLD_LIMIT_EN
            rel = !own_req || at_lim;
`else
            rel = !own_req;
`endif
            if (rel) begin
               state_d = IDLE;
               gnt_d   = 4'b0000;
               enb_d   = 1'b0;
               ptr_d   = oSel + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, pointer, counter and the ffd output bank
   always_ff @(posedge iClk) begin
      if (iClr) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         cnt_q   <= 4'd0;
         oGnt    <= 4'b0000;
         oSel    <= 2'd0;
         oEnb    <= 1'b0;
         oData   <= '0;
         oValid  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         oGnt    <= gnt_d;
         oSel    <= sel_d;
         oEnb    <= enb_d;
         oData   <= data_d;
         oValid  <= valid_d;
      end
   end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Four-requester round-robin arbiter and sequencer for the shared mux/flip-flop output datapath of the cell library. It grants one requester at a time and drives the select and enable of the shared 4:1 mux path. It captures the selected requester's data word into an output register bank built from `ffd` cells, and applies a per-grant burst limit so that no requester monopolises the resource.

## Interface
Parameters:
- `WIDTH`, 8: data word width per requester.
- `HOLD_MAX`, 4: maximum grant length in cycles; legal range 1..15.

Ports:
- `iClk`, input, 1: single clock; all state updates on the rising edge.
- `iClr`, input, 1: reset, synchronous and active-high.
- `iReq`, input, 4: per-requester request, level-sensitive; bit n is requester n.
- `iData0`..`iData3`, input, WIDTH each: requester data words.
- `oGnt`, output, 4: one-hot grant, registered; all zero when idle.
- `oSel`, output, 2: mux select, the binary index of the granted requester; registered.
- `oEnb`, output, 1: mux enable, high while any grant is active; registered.
- `oData`, output, WIDTH: registered captured data word.
- `oValid`, output, 1: `oData` was loaded on the last edge.

## Operation
- Two states:
  - IDLE: no grant.
  - GRANT: one requester owns the datapath.
- Internal registers:
  - `ptr` (2 bits): round-robin start index.
  - `cnt` (4 bits): grant cycle count.
- In IDLE with `iReq` != 0, the arbiter scans indices `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4) and picks the first requester whose bit is set. At the next edge:
  - state goes to GRANT;
  - `oGnt` = one-hot of the winner;
  - `oSel` = the winner's index;
  - `oEnb` = 1;
  - `cnt` = 0.
- In IDLE with `iReq` == 0: no change.
- In GRANT, at each edge:
  - If `iReq[oSel]` = 1, then `oData` <= `iData[oSel]`, `oValid` <= 1, and `cnt` <= `cnt+1`. Otherwise `oValid` <= 0 and `oData` holds.
  - Release condition: `iReq[oSel]` = 0, or (limit enabled and `cnt` == HOLD_MAX-1 and `iReq[oSel]` = 1).
  - On release, the next state is IDLE, `oGnt` <= 0, `oEnb` <= 0, `ptr` <= `oSel+1` (mod 4), and `oSel` holds its last value.
- In IDLE, `oValid` <= 0 and `oData` holds.
- Requests from non-granted requesters are ignored during GRANT. There is no pre-emption.
- Reset values: state IDLE, `oGnt` 0000, `oSel` 00, `oEnb` 0, `oData` 0, `oValid` 0, `ptr` 0, `cnt` 0.

## Timing
- Arbitration latency: a request sampled in IDLE at edge k gives `oGnt` asserted after edge k.
- First data: `oData` and `oValid` are valid after edge k+1, provided the request is still high at k+1.
- Data words: every edge in GRANT with the request high loads exactly one word. A requester drives its next word after seeing `oValid`, or drives a constant stream.
- Turnaround: at least one IDLE cycle between consecutive grants, including same-requester re-grant. Back-to-back maximum throughput is HOLD_MAX words per HOLD_MAX+1 cycles.
- Release edge:
  - On a limit release, the word is still captured on that edge.
  - On a drop release, no word is captured.
- `iClr` is sampled at every edge and overrides all other behaviour. No data is captured on a reset edge. Reset mid-grant returns to IDLE with `ptr` = 0.
- `iReq` = 1111 continuously after reset: grants go 0, 1, 2, 3, 0, … in that order.

## Configuration
- `RR_HOLD_LIMIT_EN`
  - Defined: the burst limit is enforced. A grant ends after HOLD_MAX captured words, even if the request stays high.
  - Undefined: `cnt` does not gate release. A grant lasts until the owner drops `iReq`; `cnt` may be optimised away. Round-robin order is unchanged.

## Test plan
- Reset: drive `iClr` = 1 for 2 cycles with random inputs, then release. Required: all outputs 0, state IDLE, `oValid` 0.
- Single requester: `iReq` = 0100 held 3 cycles, `iData2` = 8'hA5, then drop. Required:
  - `oGnt` = 0100 and `oSel` = 2 one cycle later;
  - `oData` = A5 with `oValid` = 1 for 2 cycles;
  - then `oGnt` = 0000 and `ptr` = 3.
- Round robin: `iReq` = 1111 constant, limit enabled, HOLD_MAX = 4. Required: grant sequence 0001, 0010, 0100, 1000, 0001; each grant lasts 4 cycles with 4 valid words, followed by 1 IDLE cycle.
- Pointer wrap: after a grant to requester 3 ends, assert `iReq` = 1001. Required: requester 0 is granted next, then requester 3.
- Limit disabled: `iReq` = 0011 held 10 cycles. Required: requester 0 holds the grant all 10 cycles; requester 1 is granted only after requester 0 drops.
- Reset mid-grant: assert `iClr` during the second word of a grant to requester 1. Required: the next cycle has `oGnt` 0000 and `oValid` 0, and `oData` = 0 with no capture. With `iReq` = 0010 still high, requester 1 is re-granted one cycle after `iClr` falls.
